// File: rtl/divider_pkg.sv
// Shared types and default widths for the restoring divider.
// Holds the two-state FSM encoding used by the top level.
package divider_pkg;

  localparam int DIV_NUM_BITS_DEF = 8;
  localparam int DIV_DEN_BITS_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

endpackage

// File: rtl/divider_restoring_step.sv
// One restoring-division iteration: shift in a numerator bit,
// trial-subtract the divisor, keep or restore the remainder.
module divider_restoring_step #(
  parameter int DEN_BITS = 8
) (
  input  logic [DEN_BITS:0]   i_rem,
  input  logic                i_bit,
  input  logic [DEN_BITS-1:0] i_den,
  output logic [DEN_BITS:0]   o_rem,
  output logic                o_qbit
);

  logic [DEN_BITS+1:0] w_diff;
  logic                w_neg;

  assign w_diff = {i_rem, i_bit} - {2'b00, i_den};
  assign w_neg  = w_diff[DEN_BITS+1];

  // Non-negative trial keeps the difference, otherwise restore.
  always_comb begin
    o_qbit = ~w_neg;
    o_rem  = w_diff[DEN_BITS:0];
    if (w_neg) begin
      o_rem = {i_rem[DEN_BITS-1:0], i_bit};
    end
  end

endmodule

// File: rtl/divider_restoring_unsigned.sv
// Multi-cycle unsigned restoring divider, one quotient bit per CE edge.
// Optional busy output enabled by defining DIVIDER_BUSY_PORT_EN.
module divider_restoring_unsigned
  import divider_pkg::*;
#(
  parameter int DIV_NUM_BITS = DIV_NUM_BITS_DEF,
  parameter int DIV_DEN_BITS = DIV_DEN_BITS_DEF
) (
  input  logic                    CLK,
  input  logic                    ARST_N,
  input  logic                    CE,
  input  logic [DIV_NUM_BITS-1:0] NUMERATOR_IN,
  input  logic [DIV_DEN_BITS-1:0] DENOMINATOR_IN,
  input  logic                    start,
  output logic [DIV_NUM_BITS-1:0] QUOTENT_OUT,
  output logic [DIV_DEN_BITS-1:0] REMAINDER_OUT,
  output logic                    error,
`ifdef DIVIDER_BUSY_PORT_EN
  output logic                    busy,
`endif
  output logic                    done
);

  localparam int CW = (DIV_NUM_BITS > 1) ? $clog2(DIV_NUM_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_NUM_BITS - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [CW-1:0]           r_cnt;
  logic [DIV_DEN_BITS:0]   r_rem;
  logic [DIV_NUM_BITS-1:0] r_nq;
  logic [DIV_DEN_BITS-1:0] r_den;

  logic [DIV_DEN_BITS:0]   w_rem;
  logic                    w_qbit;
  logic                    w_den_zero;
  logic                    w_last;
  logic [DIV_NUM_BITS-1:0] w_nq;

  assign w_den_zero = (r_den == '0);
  assign w_last     = (r_cnt == LAST);
  assign w_nq       = {r_nq[DIV_NUM_BITS-2:0], w_qbit};

`ifdef DIVIDER_BUSY_PORT_EN
  assign busy = (r_state == CALC);
`endif

  divider_restoring_step #(
    .DEN_BITS (DIV_DEN_BITS)
  ) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_nq[DIV_NUM_BITS-1]),
    .i_den  (r_den),
    .o_rem  (w_rem),
    .o_qbit (w_qbit)
  );

  // State register, advances only on CE-qualified edges.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_state <= IDLE;
    end else if (CE) begin
      r_state <= w_next;
    end
  end

  // Next state: accept in IDLE, leave CALC on zero divisor or last bit.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = CALC;
      CALC: if (w_den_zero || w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and result load.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_cnt         <= '0;
      r_rem         <= '0;
      r_nq          <= '0;
      r_den         <= '0;
      QUOTENT_OUT   <= '0;
      REMAINDER_OUT <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else if (CE) begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_nq  <= NUMERATOR_IN;
            r_den <= DENOMINATOR_IN;
            r_rem <= '0;
            r_cnt <= '0;
            done  <= 1'b0;
            error <= 1'b0;
          end
        end
        CALC: begin
          if (w_den_zero) begin
            QUOTENT_OUT   <= '1;
            REMAINDER_OUT <= '0;
            error         <= 1'b1;
            done          <= 1'b1;
          end else begin
            r_rem <= w_rem;
            r_nq  <= w_nq;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              QUOTENT_OUT   <= w_nq;
              REMAINDER_OUT <= w_rem[DIV_DEN_BITS-1:0];
              done          <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_restoring_unsigned.sv
// Self-checking bench for divider_restoring_unsigned (8/8 widths).
// Table vectors, hand sequences and random runs via a result queue.
module tb_divider_restoring_unsigned;

  logic       CLK = 1'b0;
  logic       ARST_N;
  logic       CE;
  logic [7:0] NUMERATOR_IN;
  logic [7:0] DENOMINATOR_IN;
  logic       start;
  logic [7:0] QUOTENT_OUT;
  logic [7:0] REMAINDER_OUT;
  logic       error;
  logic       done;
`ifdef DIVIDER_BUSY_PORT_EN
  logic       busy;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       err;
  } res_t;

  typedef struct {
    logic [7:0] n;
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] r;
    logic       err;
    int         stall_at;
    int         stall_len;
    int         lat;
  } vec_t;

  res_t sb[$];

  divider_restoring_unsigned dut (
    .CLK            (CLK),
    .ARST_N         (ARST_N),
    .CE             (CE),
    .NUMERATOR_IN   (NUMERATOR_IN),
    .DENOMINATOR_IN (DENOMINATOR_IN),
    .start          (start),
    .QUOTENT_OUT    (QUOTENT_OUT),
    .REMAINDER_OUT  (REMAINDER_OUT),
    .error          (error),
`ifdef DIVIDER_BUSY_PORT_EN
    .busy           (busy),
`endif
    .done           (done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive one division, push its expectation, wait for done, compare.
  task automatic do_div(input logic [7:0] n, input logic [7:0] d,
                        input res_t exp, input int stall_at,
                        input int stall_len, input int lat,
                        input bit hold_start);
    int   edges;
    res_t got;
    @(negedge CLK);
    NUMERATOR_IN   = n;
    DENOMINATOR_IN = d;
    start          = 1'b1;
    CE             = 1'b1;
    sb.push_back(exp);
    @(posedge CLK);
    #1;
    chk("done_cleared_on_accept", done, 0);
`ifdef DIVIDER_BUSY_PORT_EN
    chk("busy_in_calc", busy, 1);
`endif
    if (hold_start) begin
      NUMERATOR_IN   = 8'($urandom);
      DENOMINATOR_IN = 8'($urandom);
    end else begin
      start = 1'b0;
    end
    edges = 0;
    while (!done && edges < 100) begin
      CE = (edges >= stall_at && edges < stall_at + stall_len) ? 1'b0 : 1'b1;
      @(posedge CLK);
      #1;
      edges++;
    end
    start = 1'b0;
    CE    = 1'b1;
    if (!done) begin
      failures++;
      checks++;
      $display("FAIL done_timeout actual=%0d required=%0d", edges, lat);
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      chk("quotient", QUOTENT_OUT, got.q);
      chk("remainder", REMAINDER_OUT, got.r);
      chk("error", error, got.err);
      chk("latency", edges, lat);
`ifdef DIVIDER_BUSY_PORT_EN
      chk("busy_after_done", busy, 0);
`endif
    end
  endtask

  function automatic res_t model(input logic [7:0] n, input logic [7:0] d);
    res_t m;
    if (d == 0) begin
      m.q = 8'hFF;
      m.r = 8'h00;
      m.err = 1'b1;
    end else begin
      m.q = n / d;
      m.r = n % d;
      m.err = 1'b0;
    end
    return m;
  endfunction

  initial begin
    vec_t tbl[6];
    res_t e;
    logic [7:0] rn;
    logic [7:0] rd;

    tbl[0] = '{8'd0,   8'd0,   8'hFF,  8'd0, 1'b1, 0, 0, 1};
    tbl[1] = '{8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 0, 0, 8};
    tbl[2] = '{8'd0,   8'd255, 8'd0,   8'd0, 1'b0, 0, 0, 8};
    tbl[3] = '{8'd200, 8'd7,   8'd28,  8'd4, 1'b0, 0, 0, 8};
    tbl[4] = '{8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 3, 3, 11};
    tbl[5] = '{8'd13,  8'd20,  8'd0,   8'd13, 1'b0, 0, 0, 8};

    ARST_N = 1'b0;
    CE = 1'b0;
    start = 1'b0;
    NUMERATOR_IN = '0;
    DENOMINATOR_IN = '0;
    #12;
    chk("rst_q", QUOTENT_OUT, 0);
    chk("rst_r", REMAINDER_OUT, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
`ifdef DIVIDER_BUSY_PORT_EN
    chk("rst_busy", busy, 0);
`endif
    @(negedge CLK);
    ARST_N = 1'b1;
    CE = 1'b1;

    for (int i = 0; i < 6; i++) begin
      e.q = tbl[i].q;
      e.r = tbl[i].r;
      e.err = tbl[i].err;
      do_div(tbl[i].n, tbl[i].d, e, tbl[i].stall_at,
             tbl[i].stall_len, tbl[i].lat, 1'b0);
    end

    // Results hold while idle without a new start.
    repeat (4) @(posedge CLK);
    #1;
    chk("hold_done", done, 1);
    chk("hold_q", QUOTENT_OUT, 0);
    chk("hold_r", REMAINDER_OUT, 13);

    // start held high with changing operands during CALC is ignored.
    e.q = 8'd33;
    e.r = 8'd1;
    e.err = 1'b0;
    do_div(8'd100, 8'd3, e, 0, 0, 8, 1'b1);

    // Reset in the middle of CALC aborts the operation.
    @(negedge CLK);
    NUMERATOR_IN = 8'd77;
    DENOMINATOR_IN = 8'd5;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    ARST_N = 1'b0;
    #1;
    chk("abort_q", QUOTENT_OUT, 0);
    chk("abort_r", REMAINDER_OUT, 0);
    chk("abort_done", done, 0);
    chk("abort_error", error, 0);
    @(negedge CLK);
    ARST_N = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        @(posedge CLK);
        #1;
        if (done) seen++;
      end
      chk("no_done_after_abort", seen, 0);
    end
    chk("abort_q_stays", QUOTENT_OUT, 0);

    // Random back-to-back operations, a share with a zero divisor.
    for (int k = 0; k < 1000; k++) begin
      rn = 8'($urandom);
      rd = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      e = model(rn, rd);
      do_div(rn, rd, e, 0, 0, (rd == 0) ? 1 : 8, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divider_restoring_unsigned.md
DIVIDER_RESTORING_UNSIGNED -- requirements
Module: divider_restoring_unsigned

Interface
REQ-001 Parameter DIV_NUM_BITS, default 8: numerator and quotient width, SHALL be >= 2.
REQ-002 Parameter DIV_DEN_BITS, default 8: denominator and remainder width, SHALL be >= 1.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1: rising-edge clock.
REQ-005 ARST_N  input  1: asynchronous active-low reset.
REQ-006 CE  input  1: clock enable; when low, all registers SHALL hold.
REQ-007 NUMERATOR_IN  input  DIV_NUM_BITS: unsigned dividend.
REQ-008 DENOMINATOR_IN  input  DIV_DEN_BITS: unsigned divisor.
REQ-009 start  input  1: request to begin a division.
REQ-010 QUOTENT_OUT  output  DIV_NUM_BITS: unsigned quotient, registered.
REQ-011 REMAINDER_OUT  output  DIV_DEN_BITS: unsigned remainder, registered.
REQ-012 error  output  1: divide-by-zero flag for the last result.
REQ-013 done  output  1: level, high while a valid result is held.

Function
REQ-014 States SHALL be IDLE and CALC only.
REQ-015 In IDLE with CE=1 and start=1, the rising edge SHALL capture both operands, clear done and error, and enter CALC.
REQ-016 start SHALL be ignored in CALC; operands SHALL be sampled only on the accepting edge.
REQ-017 CALC SHALL run restoring division MSB-first, one quotient bit per CE-qualified edge: partial remainder (DIV_DEN_BITS+1 bits) shifted left with the next numerator bit, trial-subtract the denominator, keep the difference and set the quotient bit to 1 if non-negative, else restore and set it to 0.
REQ-018 After exactly DIV_NUM_BITS CE-qualified CALC edges, the module SHALL load QUOTENT_OUT and REMAINDER_OUT, set done=1, and return to IDLE.
REQ-019 Latency SHALL be DIV_NUM_BITS CE-qualified edges from the accepting edge to done=1.
REQ-020 Results SHALL satisfy N = Q*D + R with R < D, for all unsigned operands.
REQ-021 If the captured denominator is 0, the next CE-qualified edge SHALL set error=1, done=1, QUOTENT_OUT all ones and REMAINDER_OUT 0, and return to IDLE.
REQ-022 done, error and the result outputs SHALL hold until the next accepted start.
REQ-023 CE low during CALC SHALL stall the iteration without corrupting state.

Reset
REQ-024 ARST_N low SHALL immediately force IDLE, done=0, error=0, QUOTENT_OUT=0, REMAINDER_OUT=0, and clear the internal counter and partial remainder.
REQ-025 Reset asserted during CALC SHALL abort the operation; no done pulse SHALL follow release.

Configuration
REQ-026 Macro DIVIDER_BUSY_PORT_EN defined: the module SHALL add an output busy (1 bit), high exactly while in CALC (including the divide-by-zero cycle) and 0 in reset.
REQ-027 Macro DIVIDER_BUSY_PORT_EN undefined: no busy port SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-028 Package divider_pkg SHALL hold the state enum typedef (IDLE, CALC) and the default width constants.
REQ-029 One combinational sub-module divider_restoring_step SHALL implement the single shift/trial-subtract/restore iteration, instantiated once.

Verification
REQ-030 Test N=0, D=0 -> error=1, done=1 one edge after acceptance.
REQ-031 Test N=255, D=255 -> Q=1, R=0, done after 8 edges, error=0.
REQ-032 Test N=0, D=255 -> Q=0, R=0; then N=200, D=7 -> Q=28, R=4.
REQ-033 Test N=255, D=1 -> Q=255, R=0; hold CE low for 3 cycles mid-CALC -> done after 11 edges with the same result.
REQ-034 Assert ARST_N during CALC, then release -> outputs 0, done stays 0 until a new start; run 1000 random operand pairs back-to-back, including D=0, checked against N/D and N%D.
